// File: rtl/count_sequencer.sv
// Request/ack start sequencer: programmable start delay, then a bounded up-count held in DONE until acknowledged.
// Optional abort support is enabled with the COUNT_SEQ_ABORT_EN macro.
module count_sequencer #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned DLY_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [DLY_W-1:0] delay_cfg,
    input  logic [CNT_W-1:0] limit_cfg,
    input  logic             done_ack,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
`ifdef COUNT_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        COUNT,
        DONE
    } state_t;

    state_t           state;
    logic [DLY_W-1:0] dly;
    logic [CNT_W-1:0] lim;
    logic             abort_req;

`ifdef COUNT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dly   <= '0;
            lim   <= '0;
            count <= '0;
            ack   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef COUNT_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef COUNT_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        dly   <= delay_cfg;
                        lim   <= limit_cfg;
                        count <= '0;
                        ack   <= 1'b1;
                        busy  <= 1'b1;
                        state <= (delay_cfg != '0) ? DELAY : COUNT;
                    end
                end
                DELAY: begin
                    // abort wins over the DELAY->COUNT transition
                    if (abort_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef COUNT_SEQ_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else begin
                        dly <= dly - 1'b1;
                        if (dly == DLY_W'(1)) state <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef COUNT_SEQ_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else if (count < lim) begin
                        count <= count + 1'b1;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
